// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster constants, colour type and colour-bar helper.
// Used by the scan controller and by the pixel printer (which needs the column count).
package vga_timing_pkg;

  // Horizontal timing, pixels
  localparam int unsigned H_VIS   = 640;
  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  // Vertical timing, lines
  localparam int unsigned V_VIS   = 480;
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BP    = 33;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int unsigned PIX_TOTAL = H_VIS * V_VIS;
  localparam int unsigned TICK_DIV  = 4;

  // Level driven on HS/VS while inside the sync pulse
  localparam logic SYNC_ACT = 1'b0;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ADDR_W = 19;

  // Colour bars: eight equal columns across the visible line
  localparam int unsigned BAR_W = 80;
  localparam logic [7:0][11:0] BAR_RGB = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Bar colour for column h; threshold compares keep this free of a divider
  function automatic rgb_t test_bar(input logic [CNT_W-1:0] h);
    rgb_t c;
    c = rgb_t'(BAR_RGB[7]);
    for (int i = 6; i >= 0; i--) begin
      if (h < CNT_W'((i + 1) * BAR_W)) c = rgb_t'(BAR_RGB[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// vga_scan_ctrl_if: printer address/colour and VGA connector signals of the scan controller.
// test_mode exists only when VGA_SCAN_CTRL_TESTPAT_EN is defined.
interface vga_scan_ctrl_if;
  import vga_timing_pkg::*;

  logic [ADDR_W-1:0] pix_addr;
  logic [3:0]        pix_R;
  logic [3:0]        pix_G;
  logic [3:0]        pix_B;
  logic [3:0]        vga_R;
  logic [3:0]        vga_G;
  logic [3:0]        vga_B;
  logic              vga_HS;
  logic              vga_VS;
  logic              frame_start;
`ifdef VGA_SCAN_CTRL_TESTPAT_EN
  logic              test_mode;

  modport master (
    output pix_addr, vga_R, vga_G, vga_B, vga_HS, vga_VS, frame_start,
    input  pix_R, pix_G, pix_B, test_mode
  );
  modport slave (
    input  pix_addr, vga_R, vga_G, vga_B, vga_HS, vga_VS, frame_start,
    output pix_R, pix_G, pix_B, test_mode
  );
`else
  modport master (
    output pix_addr, vga_R, vga_G, vga_B, vga_HS, vga_VS, frame_start,
    input  pix_R, pix_G, pix_B
  );
  modport slave (
    input  pix_addr, vga_R, vga_G, vga_B, vga_HS, vga_VS, frame_start,
    output pix_R, pix_G, pix_B
  );
`endif

endinterface

// File: rtl/vga_pix_tick.sv
// vga_pix_tick: divide-by-TickDiv clock enable; pix_tick is high on the last count.
module vga_pix_tick #(
  parameter int unsigned TickDiv = 4
) (
  input  logic CLK_100MHz,
  input  logic rst_n,
  output logic pix_tick
);

  localparam int unsigned W = (TickDiv > 1) ? $clog2(TickDiv) : 1;

  logic [W-1:0] div_q, div_d;

  // Free-running divider, wraps right after the tick
  always_comb begin
    pix_tick = (div_q == W'(TickDiv - 1));
    div_d    = pix_tick ? '0 : div_q + W'(1);
  end

  // Divider register
  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: raster counters, linear printer address and registered VGA output stage.
// Define VGA_SCAN_CTRL_TESTPAT_EN to add test_mode and the colour-bar source.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned HVis  = H_VIS,
  parameter int unsigned HFp   = H_FP,
  parameter int unsigned HSync = H_SYNC,
  parameter int unsigned HBp   = H_BP,
  parameter int unsigned VVis  = V_VIS,
  parameter int unsigned VFp   = V_FP,
  parameter int unsigned VSync = V_SYNC,
  parameter int unsigned VBp   = V_BP
) (
  input logic             CLK_100MHz,
  input logic             rst_n,
  vga_scan_ctrl_if.master bus
);

  localparam int unsigned HTotal  = HVis + HFp + HSync + HBp;
  localparam int unsigned VTotal  = VVis + VFp + VSync + VBp;
  localparam int unsigned HSyncLo = HVis + HFp;
  localparam int unsigned HSyncHi = HSyncLo + HSync - 1;
  localparam int unsigned VSyncLo = VVis + VFp;
  localparam int unsigned VSyncHi = VSyncLo + VSync - 1;

  logic              pix_tick;
  logic [CNT_W-1:0]  h_q, h_d, h_nxt;
  logic [CNT_W-1:0]  v_q, v_d, v_nxt;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic              h_end, v_end, vis_cur, vis_nxt;
  logic              h_sync, v_sync;
  rgb_t              src_rgb, rgb_q, rgb_d;
  logic              hs_q, hs_d, vs_q, vs_d;
  logic              frame_q, frame_d;

  vga_pix_tick #(
    .TickDiv(TICK_DIV)
  ) u_pix_tick (
    .CLK_100MHz(CLK_100MHz),
    .rst_n     (rst_n),
    .pix_tick  (pix_tick)
  );

  // Raster position and running address after the coming tick; addr counts visible pixels
  always_comb begin
    h_end   = (h_q == CNT_W'(HTotal - 1));
    v_end   = (v_q == CNT_W'(VTotal - 1));
    vis_cur = (h_q < CNT_W'(HVis)) && (v_q < CNT_W'(VVis));
    h_nxt   = h_end ? '0 : h_q + CNT_W'(1);
    v_nxt   = v_q;
    if (h_end) v_nxt = v_end ? '0 : v_q + CNT_W'(1);
    addr_nxt = addr_q;
    if (h_end && v_end) addr_nxt = '0;
    else if (vis_cur)   addr_nxt = addr_q + ADDR_W'(1);
    vis_nxt    = (h_nxt < CNT_W'(HVis)) && (v_nxt < CNT_W'(VVis));
    h_d        = pix_tick ? h_nxt : h_q;
    v_d        = pix_tick ? v_nxt : v_q;
    addr_d     = pix_tick ? addr_nxt : addr_q;
    pix_addr_d = pix_tick ? (vis_nxt ? addr_nxt : '0) : pix_addr_q;
  end

  // Colour for the pixel addressed during the tick now ending
  always_comb begin
    src_rgb = '{r: bus.pix_R, g: bus.pix_G, b: bus.pix_B};
`ifdef VGA_SCAN_CTRL_TESTPAT_EN
    if (bus.test_mode) src_rgb = test_bar(h_q);
`endif
  end

  // Output stage: colour and sync describe the same (previous) position
  always_comb begin
    h_sync = (h_q >= CNT_W'(HSyncLo)) && (h_q <= CNT_W'(HSyncHi));
    v_sync = (v_q >= CNT_W'(VSyncLo)) && (v_q <= CNT_W'(VSyncHi));
    rgb_d  = rgb_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    if (pix_tick) begin
      rgb_d = vis_cur ? src_rgb : '0;
      hs_d  = h_sync ? SYNC_ACT : ~SYNC_ACT;
      vs_d  = v_sync ? SYNC_ACT : ~SYNC_ACT;
    end
    frame_d = pix_tick && h_end && v_end;
  end

  // State and output registers
  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      h_q        <= '0;
      v_q        <= '0;
      addr_q     <= '0;
      pix_addr_q <= '0;
      rgb_q      <= '0;
      hs_q       <= ~SYNC_ACT;
      vs_q       <= ~SYNC_ACT;
      frame_q    <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      addr_q     <= addr_d;
      pix_addr_q <= pix_addr_d;
      rgb_q      <= rgb_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.pix_addr    = pix_addr_q;
  assign bus.vga_R       = rgb_q.r;
  assign bus.vga_G       = rgb_q.g;
  assign bus.vga_B       = rgb_q.b;
  assign bus.vga_HS      = hs_q;
  assign bus.vga_VS      = vs_q;
  assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: full-size and shrunken-geometry scan controllers checked every clock
// against a position-from-elapsed-ticks model, plus a boundary vector table and reset cases.
module tb_vga_scan_ctrl;
  import vga_timing_pkg::*;

  // Shrunken geometry so frame wrap, vsync and frame_start are reachable quickly
  localparam int unsigned SHV = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int unsigned SVV = 4, SVF = 1, SVS = 2, SVB = 1;

  typedef struct packed {
    logic [18:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } obs_t;

  typedef struct {
    int unsigned hv, hf, hs, hb, vv, vf, vs, vb;
  } geom_t;

  typedef struct {
    int unsigned cyc;
    logic [18:0] addr;
    logic        hs;
    logic        vis;
    int unsigned src;
  } vec_t;

  localparam obs_t RESET_OBS = '{addr: '0, rgb: '0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic        CLK_100MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic        model_on = 1'b0;
  logic [11:0] key_a, key_b;
  int unsigned cyc;
  int          checks = 0;
  int          errors = 0;
  geom_t       ga = '{H_VIS, H_FP, H_SYNC, H_BP, V_VIS, V_FP, V_SYNC, V_BP};
  geom_t       gb = '{SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB};
  obs_t        obs_a, obs_b;
  vec_t        vecs [13];

  always #5 CLK_100MHz = ~CLK_100MHz;

  vga_scan_ctrl_if bus_a ();
  vga_scan_ctrl_if bus_b ();

  // Printer stand-in: colour is a keyed function of the address
  assign {bus_a.pix_R, bus_a.pix_G, bus_a.pix_B} = bus_a.pix_addr[11:0] ^ key_a;
  assign {bus_b.pix_R, bus_b.pix_G, bus_b.pix_B} = bus_b.pix_addr[11:0] ^ key_b;

`ifdef VGA_SCAN_CTRL_TESTPAT_EN
  logic tm_a = 1'b0;
  assign bus_a.test_mode = tm_a;
  assign bus_b.test_mode = 1'b0;
`endif

  vga_scan_ctrl u_dut_a (
    .CLK_100MHz(CLK_100MHz),
    .rst_n     (rst_n),
    .bus       (bus_a)
  );

  vga_scan_ctrl #(
    .HVis(SHV), .HFp(SHF), .HSync(SHS), .HBp(SHB),
    .VVis(SVV), .VFp(SVF), .VSync(SVS), .VBp(SVB)
  ) u_dut_b (
    .CLK_100MHz(CLK_100MHz),
    .rst_n     (rst_n),
    .bus       (bus_b)
  );

  assign obs_a = {bus_a.pix_addr, bus_a.vga_R, bus_a.vga_G, bus_a.vga_B,
                  bus_a.vga_HS, bus_a.vga_VS, bus_a.frame_start};
  assign obs_b = {bus_b.pix_addr, bus_b.vga_R, bus_b.vga_G, bus_b.vga_B,
                  bus_b.vga_HS, bus_b.vga_VS, bus_b.frame_start};

  // Clocks elapsed since reset release
  always @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Expected outputs after c clocks: position = ticks elapsed modulo frame size
  function automatic obs_t model(input int unsigned c, input geom_t g, input logic [11:0] key);
    int unsigned ht, ft, n, p, q, h, v;
    obs_t o;
    ht = g.hv + g.hf + g.hs + g.hb;
    ft = ht * (g.vv + g.vf + g.vs + g.vb);
    n  = c / 4;
    p  = n % ft;
    h  = p % ht;
    v  = p / ht;
    o  = RESET_OBS;
    if (h < g.hv && v < g.vv) o.addr = 19'(v * g.hv + h);
    if (n > 0) begin
      q = (n - 1) % ft;
      h = q % ht;
      v = q / ht;
      if (h < g.hv && v < g.vv) o.rgb = 12'(v * g.hv + h) ^ key;
      o.hs = !(h >= g.hv + g.hf && h < g.hv + g.hf + g.hs);
      o.vs = !(v >= g.vv + g.vf && v < g.vv + g.vf + g.vs);
      o.fs = (c % 4 == 0) && (p == 0);
    end
    return o;
  endfunction

  function automatic logic [11:0] bar_rgb(input int unsigned h);
    case (h / 80)
      0:       return 12'hFFF;
      1:       return 12'hFF0;
      2:       return 12'h0FF;
      3:       return 12'h0F0;
      4:       return 12'hF0F;
      5:       return 12'hF00;
      6:       return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got addr=%0d rgb=%03h hs=%b vs=%b fs=%b want addr=%0d rgb=%03h hs=%b vs=%b fs=%b",
               name, cyc, got.addr, got.rgb, got.hs, got.vs, got.fs,
               exp.addr, exp.rgb, exp.hs, exp.vs, exp.fs);
    end
  endtask

  // Advance to the falling edge where cyc == target, bounded
  task automatic wait_cyc(input int unsigned target);
    int guard = 0;
    while (cyc < target && guard < 20000) begin
      @(negedge CLK_100MHz);
      guard++;
    end
    if (cyc != target) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc got cyc=%0d want %0d", cyc, target);
    end
  endtask

  // Continuous scoreboard on both instances
  always @(negedge CLK_100MHz) begin
    if (model_on) begin
      check_obs("model_a", obs_a, model(cyc, ga, key_a));
      check_obs("model_b", obs_b, model(cyc, gb, key_b));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    obs_t exp;
    int unsigned n;

    // {cycle, addr, hs, prev visible, prev addr}
    vecs[0]  = '{0,    19'd0,   1'b1, 1'b0, 0};
    vecs[1]  = '{3,    19'd0,   1'b1, 1'b0, 0};
    vecs[2]  = '{4,    19'd1,   1'b1, 1'b1, 0};
    vecs[3]  = '{8,    19'd2,   1'b1, 1'b1, 1};
    vecs[4]  = '{2556, 19'd639, 1'b1, 1'b1, 638};
    vecs[5]  = '{2560, 19'd0,   1'b1, 1'b1, 639};
    vecs[6]  = '{2564, 19'd0,   1'b1, 1'b0, 0};
    vecs[7]  = '{2627, 19'd0,   1'b1, 1'b0, 0};
    vecs[8]  = '{2628, 19'd0,   1'b0, 1'b0, 0};
    vecs[9]  = '{3011, 19'd0,   1'b0, 1'b0, 0};
    vecs[10] = '{3012, 19'd0,   1'b1, 1'b0, 0};
    vecs[11] = '{3200, 19'd640, 1'b1, 1'b0, 0};
    vecs[12] = '{3204, 19'd641, 1'b1, 1'b1, 640};

    key_a = 12'($urandom);
    key_b = 12'($urandom);
    model_on = 1'b1;
    repeat (10) @(posedge CLK_100MHz);
    @(negedge CLK_100MHz);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      wait_cyc(vecs[i].cyc);
      exp      = RESET_OBS;
      exp.addr = vecs[i].addr;
      exp.hs   = vecs[i].hs;
      exp.rgb  = vecs[i].vis ? (12'(vecs[i].src) ^ key_a) : 12'h000;
      check_obs($sformatf("vec%0d", i), obs_a, exp);
    end

    // Mid-frame reset at (300,5): outputs clear at once, not at the next edge
    wait_cyc(4 * (5 * 800 + 300) + 2);
    #2 rst_n = 1'b0;
    #1;
    check_obs("async_rst_a", obs_a, RESET_OBS);
    check_obs("async_rst_b", obs_b, RESET_OBS);
    repeat (3) @(posedge CLK_100MHz);
    @(negedge CLK_100MHz);
    rst_n = 1'b1;
    wait_cyc(3);
    check_obs("restart_c3", obs_a, RESET_OBS);
    wait_cyc(4);
    exp      = RESET_OBS;
    exp.addr = 19'd1;
    exp.rgb  = key_a;
    check_obs("restart_c4", obs_a, exp);

    // Random run length, then a randomly placed reset of random length
    n = $urandom_range(4000, 8000);
    repeat (n) @(negedge CLK_100MHz);
    #($urandom_range(1, 4)) rst_n = 1'b0;
    #0.5;
    check_obs("rand_rst_a", obs_a, RESET_OBS);
    repeat ($urandom_range(1, 5)) @(posedge CLK_100MHz);
    @(negedge CLK_100MHz);
    rst_n = 1'b1;
    repeat (6000) @(negedge CLK_100MHz);

`ifdef VGA_SCAN_CTRL_TESTPAT_EN
    model_on = 1'b0;
    #1 tm_a = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge CLK_100MHz);
    @(negedge CLK_100MHz);
    rst_n = 1'b1;
    begin
      int unsigned hs_list [6] = '{0, 79, 80, 159, 560, 639};
      for (int i = 0; i < 6; i++) begin
        wait_cyc(4 * (hs_list[i] + 1));
        exp     = model(cyc, ga, key_a);
        exp.rgb = bar_rgb(hs_list[i]);
        check_obs($sformatf("bar_h%0d", hs_list[i]), obs_a, exp);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
